// File: rtl/alu_defs.sv
// alu_defs: shared ALU opcodes, datapath widths and multiply-sequencer state encoding.
package alu_defs;

  localparam int unsigned AW  = 16;
  localparam int unsigned OPW = 3;
  localparam int unsigned SHW = 4;
  localparam int unsigned ITW = 5;

  localparam logic [OPW-1:0] OP_AND = 3'b000;
  localparam logic [OPW-1:0] OP_OR  = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_SLL = 3'b100;
  localparam logic [OPW-1:0] OP_SRL = 3'b101;
  localparam logic [OPW-1:0] OP_SUB = 3'b110;
  localparam logic [OPW-1:0] OP_SLT = 3'b111;

  // Iteration count at which the shift-add loop has consumed every multiplier bit
  localparam logic [ITW-1:0] ITER_MAX = ITW'(AW);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_SHM  = 3'd2,
    ST_SHQ  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// alu: existing 16-bit single-cycle ALU; shifts act on the b operand by shamt.
module alu
  import alu_defs::*;
(
  input  logic [AW-1:0]  a,
  input  logic [AW-1:0]  b,
  input  logic [OPW-1:0] op,
  input  logic [SHW-1:0] shamt,
  output logic [AW-1:0]  result,
  output logic           zero
);

  // Operation select
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      OP_SUB:  result = a - b;
      OP_SLT:  result = AW'($signed(a) < $signed(b));
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16 -> low-16 shift-add multiplier sequenced over one shared alu.
// Optional feature macro: ALU_MUL_EARLY_EXIT_EN (stop once the remaining multiplier is zero).
module alu_mul_seq
  import alu_defs::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] product
);

  state_t          state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   m;
  logic [AW-1:0]   q;
  logic [ITW-1:0]  iter;

  logic [OPW-1:0]  alu_op;
  logic [AW-1:0]   alu_b;
  logic [AW-1:0]   alu_res;
  logic            alu_zero;
  logic [ITW-1:0]  iter_nx;
  logic            exit_c;

  // ALU operand/opcode steering from the current step
  always_comb begin
    alu_op = OP_ADD;
    alu_b  = m;
    case (state)
      ST_SHM: begin
        alu_op = OP_SLL;
        alu_b  = m;
      end
      ST_SHQ: begin
        alu_op = OP_SRL;
        alu_b  = q;
      end
      default: begin
        alu_op = OP_ADD;
        alu_b  = m;
      end
    endcase
  end

  alu u_alu (
    .a      (acc),
    .b      (alu_b),
    .op     (alu_op),
    .shamt  (SHW'(1)),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign iter_nx = iter + ITW'(1);

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign exit_c = alu_zero || (iter_nx == ITER_MAX);
`else
  logic unused_zero;
  assign unused_zero = alu_zero;
  assign exit_c      = (iter_nx == ITER_MAX);
`endif

  // Sequencer state, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      iter    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            acc   <= '0;
            m     <= a;
            q     <= b;
            iter  <= '0;
            busy  <= 1'b1;
            state <= b[0] ? ST_ADD : ST_SHM;
          end
        end
        ST_ADD: begin
          acc   <= alu_res;
          state <= ST_SHM;
        end
        ST_SHM: begin
          m     <= alu_res;
          state <= ST_SHQ;
        end
        ST_SHQ: begin
          q    <= alu_res;
          iter <= iter_nx;
          if (exit_c) begin
            product <= acc;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            state <= alu_res[0] ? ST_ADD : ST_SHM;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench with a cycle-count reference model for alu_mul_seq.
// Honours ALU_MUL_EARLY_EXIT_EN for expected latencies.
module tb_alu_mul_seq;

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks;
  int n_pass;
  int cyc;
  bit chk_en;

  alu_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Latency from the multiply rule: two ops per examined bit plus one add per set bit
  function automatic int k_of(input logic [15:0] mb);
    int n;
    int pop;
    n = 16;
    if (EARLY) begin
      n = 1;
      for (int i = 0; i < 16; i++) if (mb[i]) n = i + 1;
    end
    pop = 0;
    for (int i = 0; i < n; i++) if (mb[i]) pop++;
    return 2 * n + pop;
  endfunction

  // Reference model: idle / running for K cycles / one done cycle
  typedef enum int {M_IDLE, M_RUN, M_DONE} mmode_t;
  mmode_t      mm;
  int          mrem;
  logic [15:0] mexp;
  logic [15:0] mprod;

  always @(posedge clk) begin
    if (!rst_n) begin
      mm    <= M_IDLE;
      mrem  <= 0;
      mprod <= 16'h0;
    end else begin
      case (mm)
        M_IDLE: if (start) begin
          mm   <= M_RUN;
          mrem <= k_of(b);
          mexp <= 16'(32'(a) * 32'(b));
        end
        M_RUN: begin
          if (mrem == 1) begin
            mm    <= M_DONE;
            mprod <= mexp;
          end else begin
            mrem <= mrem - 1;
          end
        end
        default: mm <= M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(mm == M_RUN));
      chk("done", 32'(done), 32'(mm == M_DONE));
      chk("product", 32'(product), 32'(mprod));
    end
  end

  // Waits at negedges until done, returning the cycle count since the accept edge
  task automatic wait_done(input int t0, output int k);
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_seen", 32'(done), 32'd1);
    k = cyc - t0;
  endtask

  task automatic run_op(input string nm, input logic [15:0] opa, input logic [15:0] opb,
                        input logic [15:0] exp_p, input int exp_k);
    int t0;
    int k;
    @(negedge clk);
    a = opa;
    b = opb;
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    a = 16'h5A5A;
    b = 16'hA5A5;
    wait_done(t0, k);
    chk({nm, "_product"}, 32'(product), 32'(exp_p));
    if (exp_k > 0) chk({nm, "_latency"}, 32'(k), 32'(exp_k));
    @(negedge clk);
    chk({nm, "_idle_after"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int t0;
    int k;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = 16'h0;
    b        = 16'h0;

    // Pin the model's latency rule to hand-computed values
    chk("model_k_3x5", 32'(k_of(16'd5)), EARLY ? 32'd8 : 32'd34);
    chk("model_k_4941", 32'(k_of(16'h4941)), EARLY ? 32'd35 : 32'd37);
    chk("model_k_ffff", 32'(k_of(16'hFFFF)), 32'd48);

    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_out", 32'({busy, done, product}), 32'd0);
    rst_n = 1'b1;

    run_op("mul_3x5", 16'd3, 16'd5, 16'h000F, EARLY ? 8 : 34);
    run_op("mul_7325", 16'h7325, 16'h4941, 16'hC965, EARLY ? 35 : 37);
    run_op("mul_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 48);
    run_op("mul_b0", 16'h1234, 16'h0000, 16'h0000, EARLY ? 2 : 32);
    run_op("mul_msb", 16'h0003, 16'h8000, 16'h8000, 33);

    // Start pulsed while busy with other operands is ignored
    @(negedge clk);
    a = 16'd3;
    b = 16'd5;
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 16'd7;
    b = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, k);
    chk("ignore_product", 32'(product), 32'h000F);
    repeat (3) @(negedge clk);
    chk("ignore_no_second", 32'(busy), 32'd0);

    // Start held high: second op accepted on the edge after the idle cycle
    a = 16'd3;
    b = 16'd5;
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    wait_done(t0, k);
    chk("hold_product1", 32'(product), 32'h000F);
    @(negedge clk);
    chk("hold_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("hold_restart", 32'(busy), 32'd1);
    t0 = cyc;
    start = 1'b0;
    a = 16'hAAAA;
    b = 16'hAAAA;
    wait_done(t0, k);
    chk("hold_product2", 32'(product), 32'h000F);
    chk("hold_latency2", 32'(k), EARLY ? 32'd8 : 32'd34);
    @(negedge clk);

    // Reset during SHM of a long operation
    a = 16'hFFFF;
    b = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_out", 32'({busy, done, product}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) chk("midreset_no_done", 32'(done), 32'd0);
    end
    run_op("post_reset", 16'h7325, 16'h4941, 16'hC965, EARLY ? 35 : 37);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
